// File: rtl/fsfifo_sync_kit.sv
// QSPI support kit: synchronous FIFO plus level and edge two-flop synchronizers.
// FIFO read data one cycle after an accepted read; synchronizers two edges in to out.
// No backpressure: writes when full (without a read) and reads when empty are dropped.
// Optional FSFIFO_ERR_FLAGS_EN adds sticky ovf_o/unf_o flags.
module fsfifo_sync_kit #(
  parameter int   WIDTH = 16,
  parameter int   DEPTH = 16,
  parameter logic R     = 1'b0
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     wr_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     rd_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   filled_o,
`ifdef FSFIFO_ERR_FLAGS_EN
  output logic                     ovf_o,
  output logic                     unf_o,
`endif
  input  logic                     lvl_d_i,
  output logic                     lvl_q_o,
  input  logic                     edg_d_i,
  output logic                     edg_q_o,
  output logic                     edg_pe_o,
  output logic                     edg_ne_o
);

  localparam int              AW       = $clog2(DEPTH);
  localparam logic [AW:0]     FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             rd_acc;
  logic             wr_acc;

  assign empty_o = (filled_o == '0);
  assign full_o  = (filled_o == FULL_CNT);

  // A read in the same cycle frees the slot, so a full FIFO still takes the write.
  assign rd_acc = rd_i && !empty_o;
  assign wr_acc = wr_i && (!full_o || rd_acc);

  always_ff @(posedge clk_i) begin
    if (wr_acc) mem[wr_ptr] <= wr_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      filled_o  <= '0;
      rd_data_o <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) begin
        rd_ptr    <= rd_ptr + 1'b1;
        rd_data_o <= mem[rd_ptr];
      end
      case ({wr_acc, rd_acc})
        2'b10:   filled_o <= filled_o + 1'b1;
        2'b01:   filled_o <= filled_o - 1'b1;
        default: filled_o <= filled_o;
      endcase
    end
  end

`ifdef FSFIFO_ERR_FLAGS_EN
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ovf_o <= 1'b0;
      unf_o <= 1'b0;
    end else begin
      if (wr_i && full_o && !rd_i) ovf_o <= 1'b1;
      if (rd_i && empty_o)         unf_o <= 1'b1;
    end
  end
`endif

  logic lvl_s1;
  logic edg_s1;
  logic edg_prev;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      lvl_s1   <= R;
      lvl_q_o  <= R;
      edg_s1   <= 1'b0;
      edg_q_o  <= 1'b0;
      edg_prev <= 1'b0;
    end else begin
      lvl_s1   <= lvl_d_i;
      lvl_q_o  <= lvl_s1;
      edg_s1   <= edg_d_i;
      edg_q_o  <= edg_s1;
      edg_prev <= edg_q_o;
    end
  end

  assign edg_pe_o = edg_q_o & ~edg_prev;
  assign edg_ne_o = ~edg_q_o & edg_prev;

endmodule

// File: tb/tb_fsfifo_sync_kit.sv
// Directed bench for fsfifo_sync_kit: queue model of the FIFO plus synchronizer latency checks.
module tb_fsfifo_sync_kit;

  localparam int WIDTH = 16;
  localparam int DEPTH = 16;

  logic              clk_i = 1'b0;
  logic              reset_i;
  logic              wr_i;
  logic [WIDTH-1:0]  wr_data_i;
  logic              rd_i;
  logic [WIDTH-1:0]  rd_data_o;
  logic              full_o;
  logic              empty_o;
  logic [4:0]        filled_o;
  logic              lvl_d_i;
  logic              lvl_q_o;
  logic              edg_d_i;
  logic              edg_q_o;
  logic              edg_pe_o;
  logic              edg_ne_o;
`ifdef FSFIFO_ERR_FLAGS_EN
  logic              ovf_o;
  logic              unf_o;
`endif

  fsfifo_sync_kit #(.WIDTH(WIDTH), .DEPTH(DEPTH), .R(1'b1)) dut (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .wr_i      (wr_i),
    .wr_data_i (wr_data_i),
    .rd_i      (rd_i),
    .rd_data_o (rd_data_o),
    .full_o    (full_o),
    .empty_o   (empty_o),
    .filled_o  (filled_o),
`ifdef FSFIFO_ERR_FLAGS_EN
    .ovf_o     (ovf_o),
    .unf_o     (unf_o),
`endif
    .lvl_d_i   (lvl_d_i),
    .lvl_q_o   (lvl_q_o),
    .edg_d_i   (edg_d_i),
    .edg_q_o   (edg_q_o),
    .edg_pe_o  (edg_pe_o),
    .edg_ne_o  (edg_ne_o)
  );

  always #5 clk_i = ~clk_i;

  int vectors     = 0;
  int miscompares = 0;

  logic [WIDTH-1:0] mq[$];     // model FIFO contents
  logic [WIDTH-1:0] exp_q[$];  // expected read results in flight
  logic [WIDTH-1:0] last_rd;
  logic             ovf_m;
  logic             unf_m;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One FIFO cycle: update the model, drive, then compare after the edge.
  task automatic cyc(input logic w, input logic [WIDTH-1:0] d, input logic r);
    logic racc;
    logic wacc;
    racc  = r && (mq.size() != 0);
    wacc  = w && ((mq.size() < DEPTH) || racc);
    ovf_m = ovf_m | (w && (mq.size() == DEPTH) && !r);
    unf_m = unf_m | (r && (mq.size() == 0));
    if (racc) exp_q.push_back(mq.pop_front());
    if (wacc) mq.push_back(d);
    wr_i      = w;
    wr_data_i = d;
    rd_i      = r;
    tick();
    wr_i = 1'b0;
    rd_i = 1'b0;
    chk("filled", 32'(filled_o), 32'(mq.size()));
    chk("empty", 32'(empty_o), 32'(mq.size() == 0));
    chk("full", 32'(full_o), 32'(mq.size() == DEPTH));
    if (racc) last_rd = exp_q.pop_front();
    chk("rd_data", 32'(rd_data_o), 32'(last_rd));
`ifdef FSFIFO_ERR_FLAGS_EN
    chk("ovf", 32'(ovf_o), 32'(ovf_m));
    chk("unf", 32'(unf_o), 32'(unf_m));
`endif
  endtask

  initial begin
    reset_i   = 1'b1;
    wr_i      = 1'b0;
    wr_data_i = '0;
    rd_i      = 1'b0;
    lvl_d_i   = 1'b0;
    edg_d_i   = 1'b0;
    last_rd   = '0;
    ovf_m     = 1'b0;
    unf_m     = 1'b0;

    // Reset for two cycles
    tick();
    tick();
    chk("rst_empty", 32'(empty_o), 32'd1);
    chk("rst_full", 32'(full_o), 32'd0);
    chk("rst_filled", 32'(filled_o), 32'd0);
    chk("rst_rd_data", 32'(rd_data_o), 32'd0);
    chk("rst_lvl_q", 32'(lvl_q_o), 32'd1);
    chk("rst_edg_q", 32'(edg_q_o), 32'd0);
    chk("rst_edg_pe", 32'(edg_pe_o), 32'd0);
    chk("rst_edg_ne", 32'(edg_ne_o), 32'd0);
`ifdef FSFIFO_ERR_FLAGS_EN
    chk("rst_ovf", 32'(ovf_o), 32'd0);
    chk("rst_unf", 32'(unf_o), 32'd0);
`endif
    reset_i = 1'b0;

    // Level synchronizer leaves its reset value R=1 two edges after release
    tick();
    chk("lvl_post_rst_1", 32'(lvl_q_o), 32'd1);
    tick();
    chk("lvl_post_rst_2", 32'(lvl_q_o), 32'd0);

    // Fill, then one dropped overflow write
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, WIDTH'(i), 1'b0);
    cyc(1'b1, 16'hBEEF, 1'b0);

    // Drain, then one ignored underflow read
    for (int i = 0; i < DEPTH; i++) cyc(1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b1);

    // Simultaneous read/write at filled=3
    for (int i = 0; i < 3; i++) cyc(1'b1, WIDTH'(16'h0030 + i), 1'b0);
    cyc(1'b1, 16'h0033, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b1);

    // Simultaneous on empty: write only
    cyc(1'b1, 16'h1234, 1'b1);
    cyc(1'b0, '0, 1'b1);

    // Simultaneous on full: both accepted, new word lands behind the other 15
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, WIDTH'(16'h5000 + i), 1'b0);
    cyc(1'b1, 16'h5FFF, 1'b1);
    for (int i = 0; i < DEPTH; i++) cyc(1'b0, '0, 1'b1);

    // Wrap-around: 40 interleaved writes and reads, occupancy kept within 1..4
    for (int i = 0; i < 3; i++) cyc(1'b1, WIDTH'(16'hA000 + i), 1'b0);
    for (int i = 3; i < 40; i++) begin
      if (i % 3 == 0) cyc(1'b1, WIDTH'(16'hA000 + i), 1'b1);
      else begin
        cyc(1'b1, WIDTH'(16'hA000 + i), 1'b0);
        cyc(1'b0, '0, 1'b1);
      end
    end
    while (mq.size() != 0) cyc(1'b0, '0, 1'b1);

    // Edge synchronizer rising edge: input set before edge k
    edg_d_i = 1'b1;
    lvl_d_i = 1'b1;
    tick();
    chk("edg_q_k", 32'(edg_q_o), 32'd0);
    chk("edg_pe_k", 32'(edg_pe_o), 32'd0);
    chk("lvl_q_k", 32'(lvl_q_o), 32'd0);
    tick();
    chk("edg_q_k1", 32'(edg_q_o), 32'd1);
    chk("edg_pe_k1", 32'(edg_pe_o), 32'd1);
    chk("edg_ne_k1", 32'(edg_ne_o), 32'd0);
    chk("lvl_q_k1", 32'(lvl_q_o), 32'd1);
    tick();
    chk("edg_q_k2", 32'(edg_q_o), 32'd1);
    chk("edg_pe_k2", 32'(edg_pe_o), 32'd0);

    // Falling edge
    edg_d_i = 1'b0;
    lvl_d_i = 1'b0;
    tick();
    chk("edg_q_f0", 32'(edg_q_o), 32'd1);
    chk("edg_ne_f0", 32'(edg_ne_o), 32'd0);
    chk("lvl_q_f0", 32'(lvl_q_o), 32'd1);
    tick();
    chk("edg_q_f1", 32'(edg_q_o), 32'd0);
    chk("edg_ne_f1", 32'(edg_ne_o), 32'd1);
    chk("edg_pe_f1", 32'(edg_pe_o), 32'd0);
    chk("lvl_q_f1", 32'(lvl_q_o), 32'd0);
    tick();
    chk("edg_ne_f2", 32'(edg_ne_o), 32'd0);
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
